// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file write-back controller.
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wb_state_t;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Write-back request FIFO with newest-match forwarding search on two read ports.
module regfile_wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0] push_data,
  output logic [ADDR_W-1:0] head_rd,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] next_rd,
  output logic [DATA_W-1:0] next_data,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              fwd1_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd2_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] mem_rd   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= push_rd;
      mem_data[wr_ptr] <= push_data;
    end
  end

  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign next_rd   = mem_rd[rd_ptr + PTR_W'(1)];
  assign next_data = mem_data[rd_ptr + PTR_W'(1)];

  // Walk oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = rd_ptr;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if ((rs1 != '0) && (mem_rd[idx] == rs1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_data[idx];
        end
        if ((rs2 != '0) && (mem_rd[idx] == rs2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_data[idx];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: queues requests and drains them into the register file
// with a setup / strobe / hold sequence so RSD and Data_in never move under Reg_Write.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_rsd,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_write,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_state_t         state;
  wb_state_t         state_d;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              load;
  logic [ADDR_W-1:0] head_rd;
  logic [ADDR_W-1:0] next_rd;
  logic [ADDR_W-1:0] load_rd;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] next_data;
  logic [DATA_W-1:0] load_data;

  // x0 requests complete the handshake but are never queued.
  assign wb_ready = (count != CNT_W'(DEPTH));
  assign push     = wb_valid && wb_ready && (wb_rd != '0);
  assign pop      = (state == HOLD);
  assign busy     = (count != '0) || (state != IDLE);

  regfile_wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .push_rd   (wb_rd),
    .push_data (wb_data),
    .head_rd   (head_rd),
    .head_data (head_data),
    .next_rd   (next_rd),
    .next_data (next_data),
    .count     (count),
    .rs1       (rs1),
    .rs2       (rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data)
  );

  // Next state; on leaving HOLD the new head is the entry behind the popped one,
  // or the request being pushed this cycle when the FIFO holds only the popped one.
  always_comb begin
    state_d   = state;
    load      = 1'b0;
    load_rd   = head_rd;
    load_data = head_data;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        if (count > CNT_W'(1)) begin
          state_d   = SETUP;
          load      = 1'b1;
          load_rd   = next_rd;
          load_data = next_data;
        end else if (push) begin
          state_d   = SETUP;
          load      = 1'b1;
          load_rd   = wb_rd;
          load_data = wb_data;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      rf_rsd   <= '0;
      rf_data  <= '0;
      rf_write <= 1'b0;
    end else begin
      state    <= state_d;
      rf_write <= (state_d == STROBE);
      if (load) begin
        rf_rsd  <= load_rd;
        rf_data <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: cycle vector table, directed corner sequences,
// and a randomized stream checked against a queue/array reference model.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int NWRITES = 1000;

  logic        clk = 1'b0;
  logic        clr;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rf_rsd;
  logic [31:0] rf_data;
  logic        rf_write;
  logic [4:0]  rs1, rs2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic        busy;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.DEPTH(DEPTH), .ADDR_W(RF_ADDR_W), .DATA_W(RF_DATA_W)) dut (
    .clk(clk), .clr(clr), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .rf_rsd(rf_rsd), .rf_data(rf_data),
    .rf_write(rf_write), .rs1(rs1), .rs2(rs2), .fwd1_hit(fwd1_hit),
    .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ready;
    logic        write;
    logic [4:0]  rsd;
    logic [31:0] rdata;
    logic        busy;
    logic        hit1;
    logic [31:0] fd1;
    logic        hit2;
    logic [31:0] fd2;
  } vec_t;

  vec_t vecs[19];

  // Reference model state for the random phase.
  wb_entry_t   q[$];
  logic [31:0] exp_rf[32];
  logic [31:0] got_rf[32];

  function automatic void fwd_model(input logic [4:0] rs, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 5'd0)
      foreach (q[i])
        if (q[i].rd == rs) begin
          hit = 1'b1;
          d   = q[i].data;
        end
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc_cyc[$];
    int          stb_cyc[$];
    logic [4:0]  stb_rd[$];
    logic [31:0] stb_dat[$];
    int          k;
    int          pulses;
    int          accepted;
    int          cyc;
    logic        pop_pending, do_pop, do_push, prev_w, h;
    logic [31:0] d;
    wb_entry_t   push_ent;

    // valid rd data rs1 rs2 | ready write rsd rdata busy hit1 fd1 hit2 fd2
    vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[6]  = '{1'b1, 5'd7, 32'h11,       5'd7, 5'd8, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[7]  = '{1'b1, 5'd7, 32'h22,       5'd7, 5'd8, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'h11,       1'b0, 32'h0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 1'b1, 1'b0, 5'd7, 32'h11,       1'b1, 1'b1, 32'h22,       1'b0, 32'h0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 1'b1, 1'b1, 5'd7, 32'h11,       1'b1, 1'b1, 32'h22,       1'b0, 32'h0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 1'b1, 1'b0, 5'd7, 32'h11,       1'b1, 1'b1, 32'h22,       1'b0, 32'h0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 1'b1, 1'b0, 5'd7, 32'h22,       1'b1, 1'b1, 32'h22,       1'b0, 32'h0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 1'b1, 1'b1, 5'd7, 32'h22,       1'b1, 1'b1, 32'h22,       1'b0, 32'h0};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 1'b1, 1'b0, 5'd7, 32'h22,       1'b1, 1'b1, 32'h22,       1'b0, 32'h0};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 1'b1, 1'b0, 5'd7, 32'h22,       1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[15] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 32'h22,       1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[16] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 32'h22,       1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[17] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 32'h22,       1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[18] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b0, 5'd7, 32'h22,       1'b0, 1'b0, 32'h0,        1'b0, 32'h0};

    clr = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("reset.rf_write", 32'(rf_write), 32'd0);
    check("reset.rf_rsd",   32'(rf_rsd),   32'd0);
    check("reset.rf_data",  rf_data,       32'd0);
    check("reset.busy",     32'(busy),     32'd0);
    check("reset.wb_ready", 32'(wb_ready), 32'd1);

    // Cycle-by-cycle table: single write, forwarding priority, x0 discard.
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      wb_valid = vecs[i].valid; wb_rd = vecs[i].rd; wb_data = vecs[i].data;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      @(negedge clk);
      check($sformatf("v%0d.wb_ready", i),  32'(wb_ready),  32'(vecs[i].ready));
      check($sformatf("v%0d.rf_write", i),  32'(rf_write),  32'(vecs[i].write));
      check($sformatf("v%0d.rf_rsd", i),    32'(rf_rsd),    32'(vecs[i].rsd));
      check($sformatf("v%0d.rf_data", i),   rf_data,        vecs[i].rdata);
      check($sformatf("v%0d.busy", i),      32'(busy),      32'(vecs[i].busy));
      check($sformatf("v%0d.fwd1_hit", i),  32'(fwd1_hit),  32'(vecs[i].hit1));
      check($sformatf("v%0d.fwd1_data", i), fwd1_data,      vecs[i].fd1);
      check($sformatf("v%0d.fwd2_hit", i),  32'(fwd2_hit),  32'(vecs[i].hit2));
      check($sformatf("v%0d.fwd2_data", i), fwd2_data,      vecs[i].fd2);
    end

    // Five back-to-back requests into a 4-deep FIFO.
    k = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      wb_valid = (k <= 5); wb_rd = 5'(k); wb_data = 32'h100 + 32'(k); rs1 = '0; rs2 = '0;
      @(negedge clk);
      if (rf_write) begin
        stb_cyc.push_back(c); stb_rd.push_back(rf_rsd); stb_dat.push_back(rf_data);
      end
      if (wb_valid && wb_ready) begin
        acc_cyc.push_back(c); k++;
      end
    end
    wb_valid = 1'b0;
    check("b2b.accepts", 32'(acc_cyc.size()), 32'd5);
    check("b2b.pulses",  32'(stb_cyc.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < acc_cyc.size())
        check($sformatf("b2b.accept_cycle%0d", i), 32'(acc_cyc[i]), (i < 4) ? 32'(i) : 32'd5);
      if (i < stb_cyc.size()) begin
        check($sformatf("b2b.strobe_cycle%0d", i), 32'(stb_cyc[i]), 32'(3 + 3 * i));
        check($sformatf("b2b.strobe_rd%0d", i),    32'(stb_rd[i]),  32'(i + 1));
        check($sformatf("b2b.strobe_data%0d", i),  stb_dat[i],      32'h101 + 32'(i));
      end
    end

    // clr during STROBE with two entries queued.
    @(posedge clk); #1; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
    @(posedge clk); #1; wb_rd = 5'd4; wb_data = 32'h44;
    @(posedge clk); #1; wb_valid = 1'b0;
    @(posedge clk); #1; clr = 1'b1;
    @(negedge clk);
    check("clr.strobe_before", 32'(rf_write), 32'd1);
    @(posedge clk); #1; clr = 1'b0;
    @(negedge clk);
    check("clr.rf_write", 32'(rf_write), 32'd0);
    check("clr.rf_rsd",   32'(rf_rsd),   32'd0);
    check("clr.rf_data",  rf_data,       32'd0);
    check("clr.busy",     32'(busy),     32'd0);
    check("clr.wb_ready", 32'(wb_ready), 32'd1);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (rf_write) pulses++;
    end
    check("clr.later_pulses", 32'(pulses), 32'd0);
    check("clr.busy_after",   32'(busy),   32'd0);

    // Random stream against the queue / register-array model.
    foreach (exp_rf[i]) begin exp_rf[i] = '0; got_rf[i] = '0; end
    q.delete();
    accepted = 0; cyc = 0;
    pop_pending = 1'b0; do_pop = 1'b0; do_push = 1'b0; prev_w = 1'b0;
    push_ent = '0;
    while ((accepted < NWRITES || busy || q.size() != 0) && cyc < 20000) begin
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(push_ent);
      #1;
      wb_valid = (accepted < NWRITES) && ($urandom_range(0, 9) < 6);
      wb_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      @(negedge clk);
      fwd_model(rs1, h, d);
      check("rand.fwd1_hit",  32'(fwd1_hit), 32'(h));
      check("rand.fwd1_data", fwd1_data,     d);
      fwd_model(rs2, h, d);
      check("rand.fwd2_hit",  32'(fwd2_hit), 32'(h));
      check("rand.fwd2_data", fwd2_data,     d);
      check("rand.wb_ready",  32'(wb_ready), 32'(q.size() != DEPTH));
      do_pop = pop_pending;
      pop_pending = 1'b0;
      if (rf_write && !prev_w) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rand.strobe_empty: got strobe rd=%0d expected no strobe", rf_rsd);
        end else begin
          check("rand.strobe_rd",   32'(rf_rsd), 32'(q[0].rd));
          check("rand.strobe_data", rf_data,     q[0].data);
        end
        checks++;
        if (rf_rsd == 5'd0) begin
          failures++;
          $display("FAIL rand.x0_write: got rd=0 expected nonzero");
        end
        got_rf[rf_rsd] = rf_data;
        pop_pending = 1'b1;
      end
      prev_w = rf_write;
      do_push = wb_valid && wb_ready && (wb_rd != 5'd0);
      push_ent = '{rd: wb_rd, data: wb_data};
      if (wb_valid && wb_ready) begin
        accepted++;
        if (wb_rd != 5'd0) exp_rf[wb_rd] = wb_data;
      end
      cyc++;
    end
    wb_valid = 1'b0;
    check("rand.completed", 32'(cyc < 20000), 32'd1);
    check("rand.accepted",  32'(accepted),    32'(NWRITES));
    for (int r = 0; r < 32; r++)
      check($sformatf("rand.rf[%0d]", r), got_rf[r], exp_rf[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
